// File: rtl/ip_extslot_pkg.sv
// Shared types and helpers for the MSX expanded-slot controller.
// The secondary-slot register holds one 2-bit slot field per 16 KiB page.
package ip_extslot_pkg;

  localparam int PAGE_W    = 2;
  localparam int NUM_PAGES = 4;

  typedef logic [PAGE_W-1:0] subslot_t;

  // Secondary-slot number that the register assigns to one page.
  function automatic subslot_t page_field(input logic [7:0] sub_reg, input logic [1:0] page);
    return sub_reg[page*PAGE_W +: PAGE_W];
  endfunction

endpackage

// File: rtl/ip_extslot_n_if.sv
// Internal MSX-50BUS signals seen by one slot device.
// The bus side is the master; the slot device is the slave.
interface ip_extslot_n_if;
  logic [15:0] bus_address;
  logic        bus_io_cs;
  logic        bus_memory_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;

  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    input  bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data
  );

  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    output bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data
  );
endinterface

// File: rtl/ip_extslot_read_pipe.sv
// Fixed-latency valid+data pipe; accepts one item per clock and delivers each
// exactly once, in order, DEPTH clocks later. Synchronous active-low reset.
module ip_extslot_read_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every stage load its predecessor's pre-edge value.
    if (!n_reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: data stages carry no reset; valid_q qualifies them and the output is zeroed when idle.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = out_valid ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/ip_extslot_n.sv
// MSX expanded-slot controller: secondary-slot register, inverted read-back
// through a fixed-latency pipe, and one-hot secondary-slot select decode.
module ip_extslot_n
  import ip_extslot_pkg::*;
#(
  parameter int          NUM_SUB      = 4,
  parameter logic [15:0] REG_ADDRESS  = 16'hFFFF,
  parameter int          READ_LATENCY = 1,
  parameter logic [7:0]  RESET_VALUE  = 8'h00
) (
  input  logic               clk,
  input  logic               n_reset,
  ip_extslot_n_if.slave      bus,
  input  logic               ext_enable,
  output logic [NUM_SUB-1:0] extslot_memory,
  output logic [7:0]         sub_reg
);

  logic     reg_hit;
  subslot_t field;

  // Only memory cycles are claimed; the register lives in memory space.
  assign bus.bus_io_cs     = 1'b0;
  assign bus.bus_memory_cs = 1'b1;

  assign reg_hit = ext_enable & bus.bus_memory & ~bus.bus_io
                 & (bus.bus_address == REG_ADDRESS);

  always_ff @(posedge clk) begin
    if (!n_reset)                     sub_reg <= RESET_VALUE;
    else if (reg_hit && bus.bus_write) sub_reg <= bus.bus_write_data;
  end

  // The pipe samples the pre-write value, so a combined read+write reads the old register.
  ip_extslot_read_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (8)
  ) u_read_pipe (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (reg_hit & bus.bus_read),
    .in_data   (~sub_reg),
    .out_valid (bus.bus_read_ready),
    .out_data  (bus.bus_read_data)
  );

  assign field = page_field(sub_reg, bus.bus_address[15:14]);

  always_comb begin
    // NOTE: every output bit gets a default first so no path through this block infers a latch.
    extslot_memory = '0;
    if (!ext_enable) begin
      extslot_memory[0] = bus.bus_memory;
    end else begin
      for (int i = 0; i < NUM_SUB; i++)
        extslot_memory[i] = bus.bus_memory && !reg_hit && (int'(field) == i);
    end
  end

endmodule

// File: tb/tb_ip_extslot_n.sv
// Bench for ip_extslot_n: three instances (latency/width variants) share one
// stimulus; a cycle-indexed reference model is compared on every falling edge.
module tb_ip_extslot_n;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        ext_en;
  logic [15:0] addr;
  logic        mem, io, rd, wr;
  logic [7:0]  wdata;

  logic [3:0] sel_a, sel_c;
  logic [1:0] sel_b;
  logic [7:0] sub_a, sub_b, sub_c;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  ip_extslot_n_if if_a ();
  ip_extslot_n_if if_b ();
  ip_extslot_n_if if_c ();

  assign if_a.bus_address = addr;  assign if_b.bus_address = addr;  assign if_c.bus_address = addr;
  assign if_a.bus_memory  = mem;   assign if_b.bus_memory  = mem;   assign if_c.bus_memory  = mem;
  assign if_a.bus_io      = io;    assign if_b.bus_io      = io;    assign if_c.bus_io      = io;
  assign if_a.bus_read    = rd;    assign if_b.bus_read    = rd;    assign if_c.bus_read    = rd;
  assign if_a.bus_write   = wr;    assign if_b.bus_write   = wr;    assign if_c.bus_write   = wr;
  assign if_a.bus_write_data = wdata;
  assign if_b.bus_write_data = wdata;
  assign if_c.bus_write_data = wdata;

  ip_extslot_n #(.NUM_SUB(4), .REG_ADDRESS(16'hFFFF), .READ_LATENCY(3), .RESET_VALUE(8'h00)) u_a (
    .clk(clk), .n_reset(n_reset), .bus(if_a.slave), .ext_enable(ext_en),
    .extslot_memory(sel_a), .sub_reg(sub_a));

  ip_extslot_n #(.NUM_SUB(2), .REG_ADDRESS(16'hFFFF), .READ_LATENCY(1), .RESET_VALUE(8'h00)) u_b (
    .clk(clk), .n_reset(n_reset), .bus(if_b.slave), .ext_enable(ext_en),
    .extslot_memory(sel_b), .sub_reg(sub_b));

  ip_extslot_n #(.NUM_SUB(4), .REG_ADDRESS(16'hFFFF), .READ_LATENCY(2), .RESET_VALUE(8'h00)) u_c (
    .clk(clk), .n_reset(n_reset), .bus(if_c.slave), .ext_enable(ext_en),
    .extslot_memory(sel_c), .sub_reg(sub_c));

  // Reference model: register value plus per-cycle logs of accepted reads and resets.
  int         cyc = 0;
  bit         hit_at [MAXC];
  bit         rst_at [MAXC];
  logic [7:0] dat_at [MAXC];
  logic [7:0] m_sub  = 8'h00;

  always @(posedge clk) begin
    bit hit;
    cyc = cyc + 1;
    if (cyc < MAXC) begin
      rst_at[cyc] = !n_reset;
      hit_at[cyc] = 1'b0;
      if (!n_reset) begin
        m_sub = 8'h00;
      end else begin
        hit = ext_en && mem && !io && (addr == 16'hFFFF);
        if (hit && rd) begin
          hit_at[cyc] = 1'b1;
          dat_at[cyc] = ~m_sub;
        end
        if (hit && wr) m_sub = wdata;
      end
    end
  end

  // A read accepted at edge k is visible in cycle k+lat-1 unless a reset edge intervened.
  function automatic bit exp_rdy(input int lat, output logic [7:0] d);
    int k;
    k = cyc - lat + 1;
    d = 8'h00;
    if (k < 1 || cyc >= MAXC || !hit_at[k]) return 1'b0;
    for (int j = k + 1; j <= cyc; j++) if (rst_at[j]) return 1'b0;
    d = dat_at[k];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_sel(input int nsub);
    int f;
    if (!ext_en) return {3'b000, mem};
    if (!mem || (!io && addr == 16'hFFFF)) return 4'b0000;
    f = int'((m_sub >> (2 * int'(addr[15:14]))) & 8'h03);
    if (f < nsub) return 4'(1 << f);
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Ready-pulse logs per instance for the hand-computed timing checks.
  int         pa_c[$], pb_c[$], pc_c[$];
  logic [7:0] pa_d[$], pb_d[$], pc_d[$];

  always @(negedge clk) begin
    logic [7:0] d;
    bit r;
    if (chk_en) begin
      r = exp_rdy(3, d);
      check("a.ready", 32'(if_a.bus_read_ready), 32'(r));
      check("a.data",  32'(if_a.bus_read_data),  32'(d));
      check("a.sel",   32'(sel_a), 32'(exp_sel(4)));
      check("a.sub",   32'(sub_a), 32'(m_sub));
      check("a.cs",    32'({if_a.bus_io_cs, if_a.bus_memory_cs}), 32'h1);
      r = exp_rdy(1, d);
      check("b.ready", 32'(if_b.bus_read_ready), 32'(r));
      check("b.data",  32'(if_b.bus_read_data),  32'(d));
      check("b.sel",   32'(sel_b), 32'(exp_sel(2)));
      check("b.sub",   32'(sub_b), 32'(m_sub));
      r = exp_rdy(2, d);
      check("c.ready", 32'(if_c.bus_read_ready), 32'(r));
      check("c.data",  32'(if_c.bus_read_data),  32'(d));
      check("c.sel",   32'(sel_c), 32'(exp_sel(4)));
      check("c.sub",   32'(sub_c), 32'(m_sub));
    end
    if (if_a.bus_read_ready === 1'b1) begin pa_c.push_back(cyc); pa_d.push_back(if_a.bus_read_data); end
    if (if_b.bus_read_ready === 1'b1) begin pb_c.push_back(cyc); pb_d.push_back(if_b.bus_read_data); end
    if (if_c.bus_read_ready === 1'b1) begin pc_c.push_back(cyc); pc_d.push_back(if_c.bus_read_data); end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_bus(input logic [15:0] a, input logic m, input logic i,
                         input logic r, input logic w, input logic [7:0] d);
    addr = a; mem = m; io = i; rd = r; wr = w; wdata = d;
  endtask

  task automatic bus_idle();
    set_bus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic write_reg(input logic [7:0] d);
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, d);
    step();
    bus_idle();
  endtask

  task automatic clear_logs();
    pa_c.delete(); pa_d.delete();
    pb_c.delete(); pb_d.delete();
    pc_c.delete(); pc_d.delete();
  endtask

  logic [3:0] tab_fwd [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] tab_rev [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [1:0] tab_b2  [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
  int req;

  initial begin
    n_reset = 1'b0;
    ext_en  = 1'b1;
    bus_idle();
    step();
    chk_en = 1'b1;
    #1;
    check("rst_sub", 32'(sub_a), 32'h00);
    check("rst_ready", 32'(if_a.bus_read_ready), 32'h0);
    check("rst_rdata", 32'(if_a.bus_read_data), 32'h00);
    step();
    n_reset = 1'b1;
    step();

    // Reset-state decode.
    set_bus(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("memory_cs", 32'(if_a.bus_memory_cs), 32'h1);
    check("io_cs", 32'(if_a.bus_io_cs), 32'h0);
    check("sub_after_reset", 32'(sub_a), 32'h00);
    check("sel_8000_reset", 32'(sel_a), 32'b0001);
    step();

    // Forward mapping 11_10_01_00, then reversed 00_01_10_11.
    write_reg(8'hE4);
    check("sub_e4", 32'(sub_a), 32'hE4);
    for (int p = 0; p < 4; p++) begin
      set_bus(16'(p) << 14, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      check($sformatf("sel_e4_page%0d", p), 32'(sel_a), 32'(tab_fwd[p]));
      check($sformatf("sel2_e4_page%0d", p), 32'(sel_b), 32'(tab_b2[p]));
      step();
    end
    write_reg(8'h1B);
    for (int p = 0; p < 4; p++) begin
      set_bus(16'(p) << 14, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      check($sformatf("sel_1b_page%0d", p), 32'(sel_a), 32'(tab_rev[p]));
      step();
    end
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("sel_reg_addr", 32'(sel_a), 32'b0000);
    step();

    // Writes that must not reach the register.
    set_bus(16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); step();
    set_bus(16'h89AB, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); step();
    set_bus(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00); step();
    ext_en = 1'b0;
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); step();
    ext_en = 1'b1;
    bus_idle();
    #1;
    check("sub_ignored_writes", 32'(sub_a), 32'h1B);

    // I/O reads are never answered.
    clear_logs();
    set_bus(16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00); step();
    set_bus(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00); step();
    bus_idle();
    repeat (5) step();
    check("io_read_no_ready_a", 32'(pa_c.size()), 32'd0);
    check("io_read_no_ready_b", 32'(pb_c.size()), 32'd0);

    // Three back-to-back register reads.
    write_reg(8'hE4);
    clear_logs();
    req = cyc;
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (3) step();
    bus_idle();
    repeat (6) step();
    check("lat3_pulses", 32'(pa_c.size()), 32'd3);
    if (pa_c.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("lat3_when%0d", i), 32'(pa_c[i] - req), 32'(3 + i));
        check($sformatf("lat3_data%0d", i), 32'(pa_d[i]), 32'h1B);
      end
    end
    check("lat1_pulses", 32'(pb_c.size()), 32'd3);
    if (pb_c.size() == 3) check("lat1_first", 32'(pb_c[0] - req), 32'd1);
    check("lat2_pulses", 32'(pc_c.size()), 32'd3);
    if (pc_c.size() == 3) check("lat2_first", 32'(pc_c[0] - req), 32'd2);

    // Read of a non-register address.
    clear_logs();
    set_bus(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); step();
    bus_idle();
    repeat (10) step();
    check("mem_read_no_ready", 32'(pa_c.size() + pb_c.size() + pc_c.size()), 32'd0);

    // Two-slot variant: fields 2 and 3 select nothing.
    set_bus(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 check("sel2_8000", 32'(sel_b), 32'b00);
    step();
    set_bus(16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 check("sel2_c000", 32'(sel_b), 32'b00);
    step();

    // Simultaneous read and write.
    clear_logs();
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55); step();
    bus_idle();
    #1 check("rw_sub", 32'(sub_b), 32'h55);
    repeat (4) step();
    check("rw_pulses", 32'(pb_c.size()), 32'd1);
    if (pb_c.size() == 1) check("rw_data", 32'(pb_d[0]), 32'h1B);

    // Reset one clock after a read request.
    clear_logs();
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); step();
    bus_idle();
    n_reset = 1'b0;
    step();
    n_reset = 1'b1;
    #1 check("rst_mid_sub", 32'(sub_c), 32'h00);
    repeat (5) step();
    check("rst_mid_lat2", 32'(pc_c.size()), 32'd0);
    check("rst_mid_lat3", 32'(pa_c.size()), 32'd0);
    check("rst_mid_lat1", 32'(pb_c.size()), 32'd1);
    if (pb_c.size() == 1) check("rst_mid_lat1_data", 32'(pb_d[0]), 32'hAA);

    // Pass-through mode.
    ext_en = 1'b0;
    set_bus(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 check("pass_8000", 32'(sel_a), 32'b0001);
    step();
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAB);
    #1 check("pass_ffff", 32'(sel_a), 32'b0001);
    step();
    set_bus(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 check("pass_no_mem", 32'(sel_a), 32'b0000);
    check("pass_sub_kept", 32'(sub_a), 32'h00);
    step();

    // Reads in flight complete after ext_enable falls.
    ext_en = 1'b1;
    clear_logs();
    set_bus(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); step();
    ext_en = 1'b0;
    bus_idle();
    repeat (5) step();
    check("inflight_lat3", 32'(pa_c.size()), 32'd1);
    if (pa_c.size() == 1) check("inflight_data", 32'(pa_d[0]), 32'hFF);
    check("inflight_lat2", 32'(pc_c.size()), 32'd1);

    repeat (2) step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ip_extslot_n.md
# ip_extslot_n

Parametrised MSX expanded-slot controller for one primary slot on the internal MSX-50BUS. It holds the secondary-slot register at a configurable memory address and answers reads with the inverted register value after a configurable latency. It decodes each memory access into a one-hot secondary-slot select vector of configurable width. A run-time `ext_enable` input turns it into a non-expanded pass-through.

## Interface
- `NUM_SUB`, 4: number of implemented secondary slots (2..4); width of `extslot_memory`.
- `REG_ADDRESS`, 16'hFFFF: memory address of the secondary-slot register.
- `READ_LATENCY`, 1: clocks from the read request to `bus_read_ready` (1..4).
- `RESET_VALUE`, 8'h00: register value after reset.

Ports:
- `clk`  in  1  system clock.
- `n_reset`  in  1  reset, synchronous, active-low.
- `bus_address`  in  16  bus address.
- `bus_io_cs`  out  1  constant 0.
- `bus_memory_cs`  out  1  constant 1.
- `bus_read_ready`  out  1  one-clock read-data-valid pulse.
- `bus_read_data`  out  8  read data; valid only while `bus_read_ready`=1, 8'h00 otherwise.
- `bus_write_data`  in  8  write data.
- `bus_read`  in  1  read request strobe, one clock.
- `bus_write`  in  1  write request strobe, one clock.
- `bus_io`  in  1  qualifies the request as I/O.
- `bus_memory`  in  1  qualifies the request as memory.
- `ext_enable`  in  1  1 = expanded mode; 0 = pass-through.
- `extslot_memory`  out  NUM_SUB  one-hot secondary-slot select.
- `sub_reg`  out  8  current register value (debug and status).

## Operation
- Register hit = `ext_enable` & `bus_memory` & !`bus_io` & (`bus_address`==REG_ADDRESS).
- Write on a register hit with `bus_write`=1: `sub_reg` <= `bus_write_data` at the next clk. `sub_reg` holds 2 bits per page: [1:0] page0 ... [7:6] page3.
- The register ignores I/O writes, writes to other addresses, and all writes while `ext_enable`=0.
- Read on a register hit with `bus_read`=1: the request enters the read pipe and captures `~sub_reg`, sampled in the request cycle.
- Reads of any other address or of I/O are never answered: `bus_read_ready` stays 0.
- Read pipe: READ_LATENCY stages of valid+data. A new request may be accepted every clock, and each accepted request produces exactly one ready pulse, in order.
- If `bus_read` and `bus_write` are both 1 on a hit, the write is performed and the read returns the inverted pre-write value.
- Select decode is combinational from `bus_memory`, `bus_address[15:14]` (page p) and `sub_reg`:
  - `extslot_memory[sub_reg[2p+1:2p]]`=1 only when `bus_memory`=1, the access is not a register hit, and the field value < NUM_SUB.
  - A field value >= NUM_SUB selects nothing.
- Pass-through (`ext_enable`=0): `extslot_memory[0]`=`bus_memory`, all other bits 0, and no register hit exists. `sub_reg` is retained.
- If `ext_enable` falls while reads are in flight, those reads still complete.

## Timing
- Reset values: `sub_reg`=RESET_VALUE, read pipe empty, `bus_read_ready`=0, `bus_read_data`=8'h00. `extslot_memory` follows the decode with `sub_reg`=RESET_VALUE.
- Reset asserted mid-read flushes the pipe; no ready pulse follows.
- Write latency is 1 clock: the select decode uses the new `sub_reg` from the first clock after the write.
- Read request at edge N gives `bus_read_ready`=1 during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1 it is registered one clock after the request.
- `bus_read_ready` is a 1-clock pulse per request. Back-to-back requests give back-to-back pulses.

## Structure
- Package `ip_extslot_pkg`:
  - `PAGE_W`=2 and `NUM_PAGES`=4.
  - typedef `subslot_t` (logic [1:0]).
  - function `page_field(sub_reg, page)`.
- Sub-module `ip_extslot_read_pipe`:
  - parameters: DEPTH=READ_LATENCY, W=8.
  - inputs: in_valid, in_data.
  - outputs: out_valid, out_data, with out_data zeroed when out_valid is low.
- The top level contains the hit decode, the register and the select decode.

## Test plan
- Reset, then check: `bus_memory_cs`=1, `bus_io_cs`=0, `sub_reg`=8'h00, and a memory access at 8000h gives `extslot_memory`=4'b0001.
- Write FFFFh<=8'b11_10_01_00. Then addresses 0000h/4000h/8000h/C000h give 0001/0010/0100/1000. Then write 8'b00_01_10_11 and check the order is reversed. An access at FFFFh selects 0000.
- Run writes and reads that must be ignored: memory writes to 1234h/89ABh, and I/O writes to FFFFh with `ext_enable`=0. `sub_reg` is unchanged and I/O reads are never answered.
- With READ_LATENCY=3: write 8'hE4, then read FFFFh on three consecutive clocks. Expect three ready pulses beginning 3 clocks after the first request, each carrying 8'h1B. A memory read of 1234h gives no ready within 10 clocks.
- With NUM_SUB=2: write 8'hE4, then accesses at 8000h and C000h select 00. Apply a simultaneous read+write of 8'h55 to FFFFh: the read returns 8'h1B and `sub_reg` becomes 8'h55.
- Assert reset one clock after a read request with READ_LATENCY=2: no ready pulse, and `sub_reg` returns to RESET_VALUE. Then drive `ext_enable`=0 and check `extslot_memory` mirrors `bus_memory` on bit 0.
